mux_rr_stream_nch: RTL and testbench
====================================

// Module: mux_rr_stream_nch
// PURPOSE
//   Parametrised N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes.
//   Picks one requesting input channel each cycle by round-robin and forwards its word
//   through a single output register.
//   Generalises the 2:1 combinational select to NCH clocked, flow-controlled sources.
//   Sits between several producer streams and one shared consumer (bus, FIFO, UART tx).
// PARAMETERS
//   WIDTH  8  data bits per channel
//   NCH    4  number of input channels (>=1)
//   CW     (NCH>1 ? $clog2(NCH) : 1)  channel-index width; derived, do not override
// PORTS
//   clk        in   1          rising-edge clock; the only clock
//   rst_n      in   1          synchronous reset, active-low
//   in_data    in   NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   in   NCH        channel i presents a word
//   in_ready   out  NCH        channel i word accepted this cycle when in_valid[i]&in_ready[i]
//   out_data   out  WIDTH      registered selected word
//   out_chan   out  CW         index of the channel that sourced out_data
//   out_valid  out  1          out_data/out_chan hold a word
//   out_ready  in   1          consumer accepts; transfer when out_valid&out_ready
//   in_last    in   NCH        only with MUX_PKT_LOCK_EN: last beat of packet on channel i
//   out_last   out  1          only with MUX_PKT_LOCK_EN: registered copy of accepted in_last
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_chan=0, out_last=0.
//     Round-robin pointer set so channel 0 has highest priority.
//     A word held in the output register is discarded.
//     in_ready is combinational and is 0 while rst_n=0.
//   - load = !out_valid | out_ready.
//     The register may accept a new word in the same cycle the old one leaves.
//     Full throughput is 1 word/clk.
//   - Arbitration is combinational.
//     Search starts at channel (last_grant+1) mod NCH, wraps to 0, and ends at last_grant.
//     The grant goes to the first channel with in_valid=1.
//     grant is one-hot or all-zero.
//   - in_ready[i] = grant[i] & load. At most one in_ready bit is high per cycle.
//   - On a transfer from channel g at posedge:
//     out_data <= word g, out_chan <= g, out_valid <= 1, last_grant <= g.
//   - If load=1 and no channel is valid, out_valid <= 0; out_data and out_chan keep their values.
//   - Stall: while out_valid=1 and out_ready=0, out_data, out_chan and out_last are held stable.
//     last_grant is unchanged and all in_ready=0.
//   - Latency: input accept to out_valid is 1 clk.
//     Combinational paths are valid->ready and out_ready->in_ready only.
//     There is no path from in_* to out_*.
//   - Fairness: with all channels continuously valid and out_ready=1, the grant order is
//     0,1,..,NCH-1,0,... A continuously valid channel waits at most NCH-1 transfers.
//   - A channel dropping in_valid before it is accepted loses nothing; no state is kept per channel.
//   - NCH=1: grant = in_valid[0]; the block behaves as a 1-deep pipeline register.
// CONFIGURATION
//   Macro: MUX_PKT_LOCK_EN (the only compile-time option).
//   - Undefined: arbitration every word; in_last and out_last ports are absent.
//   - Defined: a lock flag is set after channel g transfers a word with in_last[g]=0.
//     While locked, grant is forced to g only (other channels get in_ready=0, even if g is idle).
//     The lock is cleared by a g transfer with in_last[g]=1; round-robin resumes from g+1.
//     The lock is cleared by reset.
//     out_last <= in_last[g] on each transfer.
//     A single-beat packet (in_last=1 on its first word) never locks.
// TESTING (WIDTH=8, NCH=4)
//   1. Reset: hold rst_n=0 for 2 clk with all in_valid=1 -> in_ready=0000, out_valid=0,
//      out_data=0, out_chan=0. Release -> first out_chan=0.
//   2. All valid, out_ready=1, data ch i = 8'hA0+i, 8 clk ->
//      out_chan 0,1,2,3,0,1,2,3; out_data A0..A3 repeating; out_valid=1 every clk.
//   3. Only ch2 valid (8'h5C), out_ready=0 for 3 clk ->
//      one transfer, then in_ready=0000 and out_data=5C / out_chan=2 stable.
//      Set out_ready=1 -> ch2 accepted next.
//   4. last_grant=3, ch0 and ch3 valid -> ch0 granted (wrap); next cycle ch3.
//      in_valid=0000 with out_ready=1 -> out_valid=0 after 1 clk.
//   5. Mid-stall reset: out_valid=1, out_ready=0, pulse rst_n=0 for 1 clk ->
//      out_valid=0 next clk; the word is never delivered.
//   6. MUX_PKT_LOCK_EN: ch1 sends 3 beats (last on the 3rd) while ch0/ch2 are valid ->
//      out_chan 1,1,1 with out_last 0,0,1, then ch2, then ch0.

Source files
------------

// File: rtl/mux_rr_stream_nch.sv
// mux_rr_stream_nch
//   N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes. A round-robin
//   arbiter picks one requesting channel per cycle and forwards its word through a single
//   output register. Full throughput is one word per clock.
//
//   Optional feature (compile-time macro MUX_PKT_LOCK_EN): packet lock. After a channel
//   transfers a beat with in_last=0 the grant stays with that channel until it transfers
//   a beat with in_last=1. Adds ports in_last / out_last.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   in_data    in   NCH*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NCH, channel i presents a word
//   in_ready   out  NCH, channel i word accepted (combinational, at most one bit set)
//   out_data   out  WIDTH, registered selected word
//   out_chan   out  CW, source channel of out_data
//   out_valid  out  output register holds a word
//   out_ready  in   consumer accepts
//   in_last    in   NCH, last beat of packet (MUX_PKT_LOCK_EN only)
//   out_last   out  registered copy of accepted in_last (MUX_PKT_LOCK_EN only)

module mux_rr_stream_nch #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_PKT_LOCK_EN
  ,
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last
`endif
);

  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_chan;
  logic             r_valid;
  logic [CW-1:0]    r_last_grant;

  logic             w_load;
  logic             w_lock;
  logic             w_found;
  logic [CW-1:0]    w_gidx;
  logic [CW-1:0]    w_cand;
  logic [NCH-1:0]   w_grant;
  logic [WIDTH-1:0] w_sel_data;

`ifdef MUX_PKT_LOCK_EN
  logic r_lock;
  logic r_last;
  logic w_sel_last;
  assign w_lock   = r_lock;
  assign out_last = r_last;
`else
  assign w_lock = 1'b0;
`endif

  // The register can take a new word in the same cycle the old one leaves.
  assign w_load = !r_valid | out_ready;

  // Round-robin search from last_grant+1, wrapping, ending at last_grant itself.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = r_last_grant;
    w_cand  = r_last_grant;
    w_grant = '0;
    if (w_lock) begin
      // Locked: only the packet owner may be granted, even when it is idle.
      if (in_valid[r_last_grant]) begin
        w_found = 1'b1;
      end
    end else begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        w_cand = CW'((32'(r_last_grant) + k) % NCH);
        if (!w_found && in_valid[w_cand]) begin
          w_found = 1'b1;
          w_gidx  = w_cand;
        end
      end
    end
    if (w_found) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  // One-hot AND-OR select of the granted channel's word.
  always_comb begin
    w_sel_data = '0;
`ifdef MUX_PKT_LOCK_EN
    w_sel_last = 1'b0;
`endif
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_grant[i]) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_PKT_LOCK_EN
        w_sel_last = in_last[i];
`endif
      end
    end
  end

  assign in_ready = w_grant & {NCH{w_load & rst_n}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_chan       <= '0;
      // Pointer at the top channel so channel 0 wins first.
      r_last_grant <= CW'(NCH - 1);
`ifdef MUX_PKT_LOCK_EN
      r_last       <= 1'b0;
      r_lock       <= 1'b0;
`endif
    end else if (w_load) begin
      if (w_found) begin
        r_valid      <= 1'b1;
        r_data       <= w_sel_data;
        r_chan       <= w_gidx;
        r_last_grant <= w_gidx;
`ifdef MUX_PKT_LOCK_EN
        r_last       <= w_sel_last;
        r_lock       <= !w_sel_last;
`endif
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_rr_stream_nch.sv
module tb_mux_rr_stream_nch;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 2;
`ifdef MUX_PKT_LOCK_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N-1:0]   in_last = '1;
  logic           out_last;

  always #5 clk = ~clk;

  mux_rr_stream_nch #(.WIDTH(W), .NCH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_PKT_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

`ifndef MUX_PKT_LOCK_EN
  assign out_last = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] d;
    int           ch;
    logic         last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: register occupancy, last granted channel, packet lock.
  bit m_valid = 1'b0;
  int m_lg    = N - 1;
  bit m_lock  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    if (m_lock) return v[m_lg] ? m_lg : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_lg + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_eval();
    int   g;
    bit   ld;
    exp_t e;
    logic [N-1:0] er;
    if (!rst_n) begin
      chk("in_ready_rst", 32'(in_ready), 32'(0));
      m_valid = 1'b0;
      m_lg    = N - 1;
      m_lock  = 1'b0;
      q.delete();
      return;
    end
    ld = !m_valid || out_ready;
    g  = model_grant(in_valid);
    er = '0;
    if (ld && g >= 0) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    if (ld) begin
      if (g >= 0) begin
        e.d    = in_data[g*W +: W];
        e.ch   = g;
        e.last = PKT ? in_last[g] : 1'b0;
        q.push_back(e);
        m_valid = 1'b1;
        m_lg    = g;
        m_lock  = PKT && !in_last[g];
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic rdy, input logic [N*W-1:0] d,
                      input logic [N-1:0] l, input logic rn);
    @(negedge clk);
    in_valid  = v;
    out_ready = rdy;
    in_data   = d;
    in_last   = l;
    rst_n     = rn;
    #1;
    model_eval();
  endtask

  // Output monitor: pops the expected word whenever the DUT hands one to the consumer.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid === 1'b1 && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'(1), 32'(0));
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_chan", 32'(out_chan), 32'(e.ch));
        if (PKT) chk("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  // Occupancy: out_valid must match whether the model holds an undelivered word.
  always @(posedge clk) begin
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
  end

  logic [N*W-1:0] d_ramp;
  logic [N*W-1:0] d_rnd;

  initial begin
    for (int i = 0; i < N; i++) d_ramp[i*W +: W] = W'(8'hA0 + i);

    // 1. Reset held with all channels valid.
    step(4'hF, 1'b1, d_ramp, 4'hF, 1'b0);
    step(4'hF, 1'b1, d_ramp, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_chan", 32'(out_chan), 32'(0));

    // 2. All valid, full throughput, rotating grant.
    for (int i = 0; i < 8; i++) step(4'hF, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'h0, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'h0, 1'b1, d_ramp, 4'hF, 1'b1);

    // 3. Only ch2 valid, consumer stalled, then released.
    d_rnd = '0;
    d_rnd[2*W +: W] = 8'h5C;
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, d_rnd, 4'hF, 1'b1);
    step(4'b0100, 1'b1, d_rnd, 4'hF, 1'b1);
    step(4'h0, 1'b1, d_rnd, 4'hF, 1'b1);
    step(4'h0, 1'b1, d_rnd, 4'hF, 1'b1);

    // 4. Wrap from last_grant=3 to ch0, then ch3, then idle.
    step(4'b1000, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'b1001, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'b1001, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'h0, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'h0, 1'b1, d_ramp, 4'hF, 1'b1);

    // 5. Reset in the middle of a stall drops the held word.
    step(4'b0010, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'h0, 1'b0, d_ramp, 4'hF, 1'b1);
    step(4'h0, 1'b0, d_ramp, 4'hF, 1'b0);
    step(4'h0, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'h0, 1'b1, d_ramp, 4'hF, 1'b1);

`ifdef MUX_PKT_LOCK_EN
    // 6. Three-beat packet on ch1 holds the grant against ch0/ch2.
    step(4'b0001, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'b0111, 1'b1, d_ramp, 4'b1101, 1'b1);
    step(4'b0111, 1'b1, d_ramp, 4'b1101, 1'b1);
    step(4'b0111, 1'b1, d_ramp, 4'b1111, 1'b1);
    step(4'b0101, 1'b1, d_ramp, 4'b1111, 1'b1);
    step(4'b0001, 1'b1, d_ramp, 4'b1111, 1'b1);
    step(4'h0, 1'b1, d_ramp, 4'hF, 1'b1);
    step(4'h0, 1'b1, d_ramp, 4'hF, 1'b1);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] v;
      logic [N-1:0] l;
      for (int c = 0; c < N; c++) begin
        v[c] = ($urandom_range(0, 2) != 0);
        l[c] = ($urandom_range(0, 2) == 0);
      end
      d_rnd = {$urandom(), $urandom()};
      step(v, $urandom_range(0, 3) != 0, d_rnd, l, $urandom_range(0, 63) != 0);
    end

    // Drain.
    for (int i = 0; i < 8; i++) step(4'h0, 1'b1, d_rnd, 4'hF, 1'b1);
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
